// File: rtl/bp_fe_instr_scan_multi_pkg.sv
//------------------------------------------------------------------------------
// Module   : bp_fe_scan_pkg
// Purpose  : Shared types and constants for the multi-lane FE instruction
//            scanner: control-flow class encoding, RV opcodes, link-register
//            numbers, scan record layout and skid-buffer occupancy states.
// Revision : 1.0 - initial multi-lane release
//------------------------------------------------------------------------------
`default_nettype none

package bp_fe_scan_pkg;

    // Control-flow class carried in the low two bits of every lane record
    typedef enum logic [1:0] {
        CLASS_NONE = 2'b00,
        CLASS_JAL  = 2'b01,
        CLASS_JALR = 2'b10,
        CLASS_BR   = 2'b11
    } bp_fe_scan_class_e;

    localparam logic [6:0] c_opcode_branch = 7'b1100011;
    localparam logic [6:0] c_opcode_jal    = 7'b1101111;
    localparam logic [6:0] c_opcode_jalr   = 7'b1100111;

    localparam logic [4:0] c_reg_x0 = 5'd0;
    localparam logic [4:0] c_reg_ra = 5'd1;   // x1
    localparam logic [4:0] c_reg_t0 = 5'd5;   // x5, alternate link register

    // Default-width view of one lane record; the RTL packs lanes in the same
    // field order {imm, is_ret, is_call, class} at whatever VADDR_W is chosen.
    localparam int c_scan_vaddr_w = 39;
    localparam int c_scan_w       = c_scan_vaddr_w + 4;

    typedef struct packed {
        logic [c_scan_vaddr_w-1:0] imm;
        logic                      is_ret;
        logic                      is_call;
        bp_fe_scan_class_e         cls;
    } bp_fe_scan_s;

    // Skid-buffer occupancy
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } bp_fe_scan_buf_e;

    function automatic logic is_link_reg(input logic [4:0] r);
        return (r == c_reg_ra) || (r == c_reg_t0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bp_fe_instr_scan_multi_if.sv
//------------------------------------------------------------------------------
// Module   : bp_fe_instr_scan_multi_if
// Purpose  : Fetch-side and scan-side handshake bundle of the multi-lane
//            scanner, plus the class statistics counters.
//            slave  : scanner view (consumes fetch packets, produces scans)
//            master : environment view (I$ response + BTB/BHT consumer)
// Revision : 1.0 - initial multi-lane release
//------------------------------------------------------------------------------
`default_nettype none

interface bp_fe_instr_scan_multi_if #(
    parameter int FETCH_WIDTH = 2,
    parameter int VADDR_W     = 39,
    parameter int CNT_W       = 16
);
    localparam int SCAN_W = VADDR_W + 4;
    localparam int IDX_W  = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;

    logic                          flush_i;
    logic                          fetch_v_i;
    logic                          fetch_ready_o;
    logic [32*FETCH_WIDTH-1:0]     fetch_instr_i;
    logic [FETCH_WIDTH-1:0]        fetch_mask_i;
    logic                          scan_v_o;
    logic                          scan_ready_i;
    logic [SCAN_W*FETCH_WIDTH-1:0] scan_o;
    logic [FETCH_WIDTH-1:0]        scan_mask_o;
    logic                          any_cf_o;
    logic [IDX_W-1:0]              first_cf_idx_o;
    logic [CNT_W-1:0]              br_cnt_o;
    logic [CNT_W-1:0]              jal_cnt_o;
    logic [CNT_W-1:0]              jalr_cnt_o;

    modport slave (
        input  flush_i, fetch_v_i, fetch_instr_i, fetch_mask_i, scan_ready_i,
        output fetch_ready_o, scan_v_o, scan_o, scan_mask_o, any_cf_o,
               first_cf_idx_o, br_cnt_o, jal_cnt_o, jalr_cnt_o
    );

    modport master (
        output flush_i, fetch_v_i, fetch_instr_i, fetch_mask_i, scan_ready_i,
        input  fetch_ready_o, scan_v_o, scan_o, scan_mask_o, any_cf_o,
               first_cf_idx_o, br_cnt_o, jal_cnt_o, jalr_cnt_o
    );

endinterface

`default_nettype wire

// File: rtl/bp_fe_instr_scan_multi_lane.sv
//------------------------------------------------------------------------------
// Module   : bp_fe_instr_scan_lane
// Purpose  : Combinational pre-decode of one 32-bit instruction into
//            {imm, is_ret, is_call, class}. Masked-off lanes yield all zero.
// Ports    : instr_i [31:0]      instruction word
//            v_i                 lane valid
//            scan_o  [VADDR_W+3:0] lane record
// Revision : 1.0 - initial multi-lane release
//------------------------------------------------------------------------------
`default_nettype none

module bp_fe_instr_scan_lane
    import bp_fe_scan_pkg::*;
#(
    parameter int VADDR_W = 39      // must be >= 21 to hold a JAL offset
) (
    input  wire logic [31:0]        instr_i,
    input  wire logic               v_i,
    output logic      [VADDR_W+3:0] scan_o
);

    logic [6:0]         w_opcode;
    logic [4:0]         w_rd;
    logic [4:0]         w_rs1;
    logic [12:0]        w_imm_b;
    logic [20:0]        w_imm_j;
    logic [11:0]        w_imm_i;
    bp_fe_scan_class_e  w_cls;
    logic [VADDR_W-1:0] w_imm;
    logic               w_call;
    logic               w_ret;
    logic               w_unused;

    assign w_opcode = instr_i[6:0];
    assign w_rd     = instr_i[11:7];
    assign w_rs1    = instr_i[19:15];
    // funct3 is not needed: classification is by opcode alone
    assign w_unused = ^instr_i[14:12];

    // Immediate bit scatter of the B, J and I formats; bit 0 is implied zero
    assign w_imm_b = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign w_imm_j = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
    assign w_imm_i = instr_i[31:20];

    always_comb begin
        w_cls  = CLASS_NONE;
        w_imm  = '0;
        w_call = 1'b0;
        w_ret  = 1'b0;
        if (v_i) begin
            case (w_opcode)
                c_opcode_branch: begin
                    w_cls = CLASS_BR;
                    w_imm = {{(VADDR_W-13){w_imm_b[12]}}, w_imm_b};
                end
                c_opcode_jal: begin
                    w_cls  = CLASS_JAL;
                    w_imm  = {{(VADDR_W-21){w_imm_j[20]}}, w_imm_j};
                    w_call = is_link_reg(w_rd);
                end
                c_opcode_jalr: begin
                    w_cls  = CLASS_JALR;
                    w_imm  = {{(VADDR_W-12){w_imm_i[11]}}, w_imm_i};
                    w_call = is_link_reg(w_rd);
                    // Only the canonical "jalr x0, 0(ra|t0)" counts as a return
                    w_ret  = (w_rd == c_reg_x0) && is_link_reg(w_rs1) && (w_imm_i == 12'd0);
                end
                default: ;
            endcase
        end
    end

    assign scan_o = {w_imm, w_ret, w_call, w_cls};

endmodule

`default_nettype wire

// File: rtl/bp_fe_instr_scan_multi.sv
//------------------------------------------------------------------------------
// Module   : bp_fe_instr_scan_multi
// Purpose  : Pre-decodes FETCH_WIDTH instructions per fetch packet and passes
//            the results through a 2-entry ready/valid skid buffer.
// Ports    : clk_i, reset_i (synchronous, active high)
//            bus (slave): fetch_v_i/fetch_ready_o/fetch_instr_i/fetch_mask_i,
//                         scan_v_o/scan_ready_i/scan_o/scan_mask_o,
//                         any_cf_o/first_cf_idx_o, flush_i,
//                         br_cnt_o/jal_cnt_o/jalr_cnt_o
// Config   : BP_FE_SCAN_STATS_EN - when defined, saturating per-class lane
//            counters advance on each output handshake; otherwise the counter
//            outputs are tied to zero.
// Revision : 1.0 - initial multi-lane release
//------------------------------------------------------------------------------
`default_nettype none

module bp_fe_instr_scan_multi
    import bp_fe_scan_pkg::*;
#(
    parameter int FETCH_WIDTH = 2,
    parameter int VADDR_W     = 39,
    parameter int CNT_W       = 16
) (
    input wire logic             clk_i,
    input wire logic             reset_i,
    bp_fe_instr_scan_multi_if.slave bus
);

    localparam int SCAN_W  = VADDR_W + 4;
    localparam int IDX_W   = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
    localparam int DATA_W  = SCAN_W * FETCH_WIDTH;
    // Buffer entry: {idx, any, mask, lane records}
    localparam int ENTRY_W = IDX_W + 1 + FETCH_WIDTH + DATA_W;

    logic [DATA_W-1:0]      w_scan;
    logic [FETCH_WIDTH-1:0] w_cf;
    logic [IDX_W-1:0]       w_idx;
    logic [ENTRY_W-1:0]     w_entry;

    // ---------------- lane decode ----------------
    for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_lane
        bp_fe_instr_scan_lane #(.VADDR_W(VADDR_W)) u_lane (
            .instr_i (bus.fetch_instr_i[32*k +: 32]),
            .v_i     (bus.fetch_mask_i[k]),
            .scan_o  (w_scan[SCAN_W*k +: SCAN_W])
        );
        // Masked lanes decode to NONE, so no extra mask term is needed here
        assign w_cf[k] = (w_scan[SCAN_W*k +: 2] != CLASS_NONE);
    end

    // Lowest-numbered control-flow lane wins; scanning downward lets it overwrite
    always_comb begin
        w_idx = '0;
        for (int k = FETCH_WIDTH-1; k >= 0; k--) begin
            if (w_cf[k]) w_idx = IDX_W'(k);
        end
    end

    assign w_entry = {w_idx, |w_cf, bus.fetch_mask_i, w_scan};

    // ---------------- 2-entry skid buffer ----------------
    bp_fe_scan_buf_e    r_state;
    bp_fe_scan_buf_e    w_state_n;
    logic               r_not_full;
    logic [ENTRY_W-1:0] r_hd;
    logic [ENTRY_W-1:0] r_tl;
    logic               w_push;
    logic               w_pop;
    logic               w_ld_hd;
    logic               w_ld_tl;
    logic               w_hd_from_tl;

    // Flush drops both sides of any handshake in the same cycle
    assign w_push = bus.fetch_v_i & r_not_full & ~bus.flush_i;
    assign w_pop  = (r_state != BUF_EMPTY) & bus.scan_ready_i & ~bus.flush_i;

    always_comb begin
        w_state_n    = r_state;
        w_ld_hd      = 1'b0;
        w_ld_tl      = 1'b0;
        w_hd_from_tl = 1'b0;
        if (bus.flush_i) begin
            w_state_n = BUF_EMPTY;
        end else begin
            case (r_state)
                BUF_EMPTY: begin
                    if (w_push) begin
                        w_ld_hd   = 1'b1;
                        w_state_n = BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (w_push && w_pop) begin
                        w_ld_hd = 1'b1;          // new packet replaces departing head
                    end else if (w_push) begin
                        w_ld_tl   = 1'b1;
                        w_state_n = BUF_FULL;
                    end else if (w_pop) begin
                        w_state_n = BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    // push cannot occur here: ready was low this cycle
                    if (w_pop) begin
                        w_hd_from_tl = 1'b1;
                        w_state_n    = BUF_ONE;
                    end
                end
                default: w_state_n = BUF_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state    <= BUF_EMPTY;
            r_not_full <= 1'b1;
        end else begin
            r_state    <= w_state_n;
            r_not_full <= (w_state_n != BUF_FULL);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_hd <= '0;
            r_tl <= '0;
        end else begin
            if (w_ld_hd)           r_hd <= w_entry;
            else if (w_hd_from_tl) r_hd <= r_tl;
            if (w_ld_tl)           r_tl <= w_entry;
        end
    end

    // Ready comes from a flop; reset only masks it so nothing is accepted
    // while reset is held, and it is already high the first cycle after.
    assign bus.fetch_ready_o  = r_not_full & ~reset_i;
    assign bus.scan_v_o       = (r_state != BUF_EMPTY);
    assign bus.scan_o         = r_hd[DATA_W-1:0];
    assign bus.scan_mask_o    = r_hd[DATA_W +: FETCH_WIDTH];
    assign bus.any_cf_o       = r_hd[DATA_W + FETCH_WIDTH];
    assign bus.first_cf_idx_o = r_hd[ENTRY_W-1 -: IDX_W];

    // ---------------- class statistics ----------------
`ifdef BP_FE_SCAN_STATS_EN
    localparam int INC_W = $clog2(FETCH_WIDTH + 1);

    logic [INC_W-1:0] w_br_inc;
    logic [INC_W-1:0] w_jal_inc;
    logic [INC_W-1:0] w_jalr_inc;
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_jal_cnt;
    logic [CNT_W-1:0] r_jalr_cnt;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                                 input logic [INC_W-1:0] inc);
        logic [CNT_W:0] s;
        s = {1'b0, c} + (CNT_W+1)'(inc);
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    // Head lanes that were masked off already carry class NONE
    always_comb begin
        w_br_inc   = '0;
        w_jal_inc  = '0;
        w_jalr_inc = '0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            case (r_hd[SCAN_W*k +: 2])
                CLASS_BR:   w_br_inc   = w_br_inc   + 1'b1;
                CLASS_JAL:  w_jal_inc  = w_jal_inc  + 1'b1;
                CLASS_JALR: w_jalr_inc = w_jalr_inc + 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_br_cnt   <= '0;
            r_jal_cnt  <= '0;
            r_jalr_cnt <= '0;
        end else if (w_pop) begin
            r_br_cnt   <= sat_add(r_br_cnt,   w_br_inc);
            r_jal_cnt  <= sat_add(r_jal_cnt,  w_jal_inc);
            r_jalr_cnt <= sat_add(r_jalr_cnt, w_jalr_inc);
        end
    end

    assign bus.br_cnt_o   = r_br_cnt;
    assign bus.jal_cnt_o  = r_jal_cnt;
    assign bus.jalr_cnt_o = r_jalr_cnt;
`else
    assign bus.br_cnt_o   = '0;
    assign bus.jal_cnt_o  = '0;
    assign bus.jalr_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bp_fe_instr_scan_multi.sv
//------------------------------------------------------------------------------
// Module   : tb_bp_fe_instr_scan_multi
// Purpose  : Self-checking bench for bp_fe_instr_scan_multi (FETCH_WIDTH=2,
//            VADDR_W=39, CNT_W=4). Honours BP_FE_SCAN_STATS_EN for the
//            expected counter values.
// Revision : 1.0 - initial multi-lane release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bp_fe_instr_scan_multi;

    localparam int FW = 2;
    localparam int VW = 39;
    localparam int CW = 4;
    localparam int SW = VW + 4;
`ifdef BP_FE_SCAN_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam logic [31:0] NOP   = 32'h00000013;
    localparam logic [31:0] BEQM4 = 32'hFE000EE3;   // beq x0,x0,-4
    localparam logic [31:0] JAL8  = 32'h008000EF;   // jal x1,+8
    localparam logic [31:0] RET   = 32'h00008067;   // jalr x0,0(x1)
    localparam logic [31:0] JR16  = 32'hFF030067;   // jalr x0,-16(x6)

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bp_fe_instr_scan_multi_if #(.FETCH_WIDTH(FW), .VADDR_W(VW), .CNT_W(CW)) bus ();

    bp_fe_instr_scan_multi #(.FETCH_WIDTH(FW), .VADDR_W(VW), .CNT_W(CW)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [SW*FW-1:0] scan;
        logic [FW-1:0]    mask;
        logic             any;
        logic             idx;
    } pkt_t;

    pkt_t q[$];
    int   m_br = 0, m_jal = 0, m_jalr = 0;

    // Offsets rebuilt arithmetically from the RV immediate definitions
    function automatic logic [SW-1:0] ref_lane(input logic [31:0] ins, input logic v);
        longint imm  = 0;
        int     cls  = 0;
        bit     call = 0;
        bit     ret  = 0;
        int     rd   = int'(ins[11:7]);
        int     rs1  = int'(ins[19:15]);
        if (!v) return '0;
        case (ins[6:0])
            7'h63: begin
                cls = 3;
                imm = (ins[31] ? -64'sd4096 : 64'sd0) + longint'(ins[7]) * 2048
                    + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
            end
            7'h6F: begin
                cls  = 1;
                imm  = (ins[31] ? -64'sd1048576 : 64'sd0) + longint'(ins[19:12]) * 4096
                     + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
                call = (rd == 1) || (rd == 5);
            end
            7'h67: begin
                cls  = 2;
                imm  = (ins[31] ? -64'sd2048 : 64'sd0) + longint'(ins[30:20]);
                call = (rd == 1) || (rd == 5);
                ret  = (rd == 0) && ((rs1 == 1) || (rs1 == 5)) && (imm == 0);
            end
            default: ;
        endcase
        return {imm[VW-1:0], ret, call, 2'(cls)};
    endfunction

    function automatic pkt_t ref_pkt(input logic [31:0] i0, input logic [31:0] i1,
                                     input logic [1:0] m);
        pkt_t p;
        logic [SW-1:0] l0, l1;
        l0 = ref_lane(i0, m[0]);
        l1 = ref_lane(i1, m[1]);
        p.scan = {l1, l0};
        p.mask = m;
        p.any  = (l0[1:0] != 0) || (l1[1:0] != 0);
        p.idx  = (l0[1:0] == 0) && (l1[1:0] != 0);
        return p;
    endfunction

    function automatic int sat(input int v);
        return (v > (1 << CW) - 1) ? (1 << CW) - 1 : v;
    endfunction

    // Compare current outputs against the model, then advance the model by
    // the transfer the coming rising edge will perform.
    initial begin
        forever begin
            @(negedge clk);
            chk("scan_v", bus.scan_v_o, q.size() != 0);
            chk("fetch_ready", bus.fetch_ready_o, !rst && (q.size() < 2));
            chk("br_cnt", bus.br_cnt_o, m_br);
            chk("jal_cnt", bus.jal_cnt_o, m_jal);
            chk("jalr_cnt", bus.jalr_cnt_o, m_jalr);
            if (q.size() != 0 && bus.scan_v_o) begin
                chk("scan_data", bus.scan_o, q[0].scan);
                chk("scan_mask", bus.scan_mask_o, q[0].mask);
                chk("any_cf", bus.any_cf_o, q[0].any);
                chk("first_cf_idx", bus.first_cf_idx_o, q[0].idx);
            end
            if (rst) begin
                q.delete();
                m_br = 0; m_jal = 0; m_jalr = 0;
            end else if (bus.flush_i) begin
                q.delete();
            end else begin
                bit do_push;
                do_push = bus.fetch_v_i && (q.size() < 2);
                if (q.size() != 0 && bus.scan_ready_i) begin
                    if (STATS) begin
                        for (int k = 0; k < FW; k++) begin
                            logic [1:0] c;
                            c = q[0].scan[k*SW +: 2];
                            if (q[0].mask[k] && c == 2'd3) m_br   = sat(m_br + 1);
                            if (q[0].mask[k] && c == 2'd1) m_jal  = sat(m_jal + 1);
                            if (q[0].mask[k] && c == 2'd2) m_jalr = sat(m_jalr + 1);
                        end
                    end
                    void'(q.pop_front());
                end
                if (do_push) q.push_back(ref_pkt(bus.fetch_instr_i[31:0],
                                                 bus.fetch_instr_i[63:32],
                                                 bus.fetch_mask_i));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [31:0] i0, input logic [31:0] i1,
                       input logic [1:0] m);
        bus.fetch_v_i     = v;
        bus.fetch_instr_i = {i1, i0};
        bus.fetch_mask_i  = m;
    endtask

    logic [SW-1:0] t;
    logic [SW*FW-1:0] s;

    initial begin
        rst              = 1'b1;
        bus.flush_i      = 1'b0;
        bus.scan_ready_i = 1'b1;
        put(1'b0, NOP, NOP, 2'b00);
        repeat (3) step();

        // reset state
        chk("rst_scan_v", bus.scan_v_o, 0);
        chk("rst_ready", bus.fetch_ready_o, 0);
        chk("rst_scan", bus.scan_o, 0);
        chk("rst_any", bus.any_cf_o, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", bus.fetch_ready_o, 1);

        // pin the model's decode against hand-computed records
        t = ref_lane(BEQM4, 1'b1);
        chk("pin_beq", t, {{37{1'b1}}, 2'b00, 1'b0, 1'b0, 2'b11});
        t = ref_lane(JAL8, 1'b1);
        chk("pin_jal", t, {39'd8, 1'b0, 1'b1, 2'b01});
        t = ref_lane(RET, 1'b1);
        chk("pin_ret", t, {39'd0, 1'b1, 1'b0, 2'b10});
        t = ref_lane(JR16, 1'b1);
        chk("pin_jr16", t, {{35{1'b1}}, 4'b0000, 1'b0, 1'b0, 2'b10});
        t = ref_lane(BEQM4, 1'b0);
        chk("pin_masked", t, 0);
        step();

        // 1: nop + beq -4
        put(1'b1, NOP, BEQM4, 2'b11);
        step();
        put(1'b0, NOP, NOP, 2'b00);
        s = bus.scan_o;
        chk("t1_scan_v", bus.scan_v_o, 1);
        chk("t1_lane0", s[SW-1:0], 0);
        chk("t1_lane1", s[2*SW-1:SW], {{37{1'b1}}, 2'b00, 1'b0, 1'b0, 2'b11});
        chk("t1_any", bus.any_cf_o, 1);
        chk("t1_idx", bus.first_cf_idx_o, 1);
        step(); step();

        // 2: jal/ret packet, then jalr -16 packet
        put(1'b1, JAL8, RET, 2'b11);
        step();
        put(1'b1, JR16, NOP, 2'b11);
        s = bus.scan_o;
        chk("t2_lane0", s[SW-1:0], {39'd8, 1'b0, 1'b1, 2'b01});
        chk("t2_lane1", s[2*SW-1:SW], {39'd0, 1'b1, 1'b0, 2'b10});
        chk("t2_idx", bus.first_cf_idx_o, 0);
        step();
        put(1'b0, NOP, NOP, 2'b00);
        s = bus.scan_o;
        chk("t2_jr16", s[SW-1:0], {{35{1'b1}}, 4'b0000, 1'b0, 1'b0, 2'b10});
        step(); step();

        // 3: back-pressure, three offered, two accepted, drained in order
        bus.scan_ready_i = 1'b0;
        put(1'b1, JAL8, NOP, 2'b11);  step();
        put(1'b1, NOP, BEQM4, 2'b11); step();
        chk("t3_ready_full", bus.fetch_ready_o, 0);
        put(1'b1, RET, NOP, 2'b01);   step();
        put(1'b0, NOP, NOP, 2'b00);
        chk("t3_still_full", bus.fetch_ready_o, 0);
        bus.scan_ready_i = 1'b1;
        repeat (4) step();

        // 4: flush while full with a packet offered
        bus.scan_ready_i = 1'b0;
        put(1'b1, JAL8, NOP, 2'b11);  step();
        put(1'b1, NOP, BEQM4, 2'b11); step();
        put(1'b1, RET, NOP, 2'b11);
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        put(1'b0, NOP, NOP, 2'b00);
        chk("t4_scan_v", bus.scan_v_o, 0);
        chk("t4_ready", bus.fetch_ready_o, 1);
        bus.scan_ready_i = 1'b1;
        repeat (3) step();

        // 6: reset with two packets buffered
        bus.scan_ready_i = 1'b0;
        put(1'b1, JAL8, RET, 2'b11);  step();
        put(1'b1, BEQM4, NOP, 2'b11); step();
        put(1'b1, JR16, NOP, 2'b11);
        rst = 1'b1;
        step(); step();
        chk("t6_scan_v", bus.scan_v_o, 0);
        chk("t6_ready", bus.fetch_ready_o, 0);
        chk("t6_scan", bus.scan_o, 0);
        chk("t6_mask", bus.scan_mask_o, 0);
        chk("t6_idx", bus.first_cf_idx_o, 0);
        chk("t6_br_cnt", bus.br_cnt_o, 0);
        rst = 1'b0;
        put(1'b0, NOP, NOP, 2'b00);
        bus.scan_ready_i = 1'b1;
        step();
        put(1'b1, JAL8, JR16, 2'b11); step();
        put(1'b0, NOP, NOP, 2'b00);
        repeat (3) step();
        chk("t6_jal_cnt", bus.jal_cnt_o, STATS ? 1 : 0);
        chk("t6_jalr_cnt", bus.jalr_cnt_o, STATS ? 1 : 0);

        // 5: masked lane not counted, then saturation
        put(1'b1, BEQM4, BEQM4, 2'b01); step();
        put(1'b0, NOP, NOP, 2'b00);
        repeat (2) step();
        chk("t5_mask01_br", bus.br_cnt_o, STATS ? 1 : 0);
        put(1'b1, BEQM4, BEQM4, 2'b11);
        repeat (20) step();
        put(1'b0, NOP, NOP, 2'b00);
        repeat (3) step();
        chk("t5_br_sat", bus.br_cnt_o, STATS ? 15 : 0);
        chk("t5_idle", bus.scan_v_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
